// File: rtl/thermo_code_decoder_pkg.sv
// thermo_code_decoder_pkg: legal LED-bar codes, bin centres and FSM state encoding
package thermo_code_decoder_pkg;
  localparam logic [7:0] CODE_N4 = 8'b1000_0000;
  localparam logic [7:0] CODE_N3 = 8'b0100_0000;
  localparam logic [7:0] CODE_N2 = 8'b0010_0000;
  localparam logic [7:0] CODE_N1 = 8'b0001_0000;
  localparam logic [7:0] CODE_ZERO = 8'b0001_1000;
  localparam logic [7:0] CODE_P1 = 8'b0000_1000;
  localparam logic [7:0] CODE_P2 = 8'b0000_0100;
  localparam logic [7:0] CODE_P3 = 8'b0000_0010;
  localparam logic [7:0] CODE_P4 = 8'b0000_0001;
  localparam logic signed [15:0] LVL_N4 = -16'sd28672;
  localparam logic signed [15:0] LVL_N3 = -16'sd20480;
  localparam logic signed [15:0] LVL_N2 = -16'sd12288;
  localparam logic signed [15:0] LVL_N1 = -16'sd4096;
  localparam logic signed [15:0] LVL_ZERO = 16'sd0;
  localparam logic signed [15:0] LVL_P1 = 16'sd4096;
  localparam logic signed [15:0] LVL_P2 = 16'sd12288;
  localparam logic signed [15:0] LVL_P3 = 16'sd20480;
  localparam logic signed [15:0] LVL_P4 = 16'sd28672;
  localparam logic [7:0] LEGAL_CODES [9] = '{CODE_N4, CODE_N3, CODE_N2, CODE_N1, CODE_ZERO,
                                             CODE_P1, CODE_P2, CODE_P3, CODE_P4};
  localparam logic signed [15:0] LEVELS [9] = '{LVL_N4, LVL_N3, LVL_N2, LVL_N1, LVL_ZERO,
                                                LVL_P1, LVL_P2, LVL_P3, LVL_P4};
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
endpackage

// File: rtl/thermo_code_decoder_map.sv
// thermo_code_map: combinational LED-bar code to bin-centre level lookup
module thermo_code_map
  import thermo_code_decoder_pkg::*;
(
  input  logic [7:0]         code,
  output logic signed [15:0] level,
  output logic               legal
);
  always_comb begin
    level = '0;
    legal = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (code == LEGAL_CODES[i]) begin
        level = LEVELS[i];
        legal = 1'b1;
      end
    end
  end
endmodule

// File: rtl/thermo_code_decoder.sv
// thermo_code_decoder: debounced LED-bar code to slew-limited acceleration samples
module thermo_code_decoder
  import thermo_code_decoder_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int STEP = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         code,
  input  logic               tick,
  input  logic               out_ready,
  output logic signed [15:0] accel,
  output logic               out_valid,
  output logic               code_err,
  output logic               overrun
);
  localparam logic [7:0] SC = 8'(STABLE_CYCLES);
  localparam logic signed [16:0] STEP17 = 17'(STEP);
  logic [7:0] code_q, prev_q, cnt_q, cnt_d;
  logic signed [15:0] target_q, target_d, accel_q, accel_d, level, sat;
  logic [1:0] state_q, state_d;
  logic valid_q, valid_d, err_q, err_d, ovr_q, ovr_d, legal, changed, accept;
  logic signed [16:0] diff, delta;
  logic signed [17:0] sum;

  thermo_code_map u_map (.code(code_q), .level(level), .legal(legal));

  // accept fires once, when STABLE_CYCLES identical registered codes have been seen
  always_comb begin
    changed = code_q != prev_q;
    cnt_d = changed ? 8'd0 : (cnt_q == SC ? cnt_q : cnt_q + 8'd1);
    accept = (SC == 8'd1) || (!changed && cnt_q == SC - 8'd2);
    target_d = accept && legal ? level : target_q;
    err_d = accept ? !legal : err_q;
    diff = {target_q[15], target_q} - {accel_q[15], accel_q};
    delta = diff > STEP17 ? STEP17 : (diff < -STEP17 ? -STEP17 : diff);
    sum = {delta[16], delta} + {{2{accel_q[15]}}, accel_q};
    sat = sum > 18'sd32767 ? 16'sh7fff : (sum < -18'sd32768 ? 16'sh8000 : sum[15:0]);
    state_d = state_q == ST_IDLE ? (tick ? ST_STEP : ST_IDLE)
            : state_q == ST_STEP ? ST_PRESENT
            : out_ready ? (tick ? ST_STEP : ST_IDLE) : ST_PRESENT;
    accel_d = state_q == ST_STEP ? sat : accel_q;
    valid_d = state_q == ST_STEP ? 1'b1 : (state_q != ST_IDLE && out_ready ? 1'b0 : valid_q);
    ovr_d = ovr_q | (tick & (state_q == ST_STEP | (state_q != ST_IDLE & !out_ready)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= CODE_ZERO;
      prev_q <= CODE_ZERO;
      cnt_q <= '0;
      target_q <= '0;
      accel_q <= '0;
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      code_q <= code;
      prev_q <= code_q;
      cnt_q <= cnt_d;
      target_q <= target_d;
      accel_q <= accel_d;
      state_q <= state_d;
      valid_q <= valid_d;
      err_q <= err_d;
      ovr_q <= ovr_d;
    end
  end

  assign accel = accel_q;
  assign out_valid = valid_q;
  assign code_err = err_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_thermo_code_decoder.sv
// tb_thermo_code_decoder: scenario tasks checked against a behavioural run-length/slew model
module tb_thermo_code_decoder;
  localparam int STABLE = 4;
  localparam int STEP_SZ = 1024;
  localparam logic [7:0] ZERO = 8'b0001_1000;
  logic clk = 1'b0, rst = 1'b0, tick = 1'b0, out_ready = 1'b1;
  logic [7:0] code = ZERO;
  logic signed [15:0] accel;
  logic out_valid, code_err, overrun;
  int checks = 0, failures = 0;
  logic [7:0] m_val;
  int m_run, m_target, m_accel;
  logic m_err;

  thermo_code_decoder #(.STABLE_CYCLES(STABLE), .STEP(STEP_SZ)) dut (
    .clk(clk), .rst(rst), .code(code), .tick(tick), .out_ready(out_ready),
    .accel(accel), .out_valid(out_valid), .code_err(code_err), .overrun(overrun));

  always #5 clk = ~clk;

  function automatic bit is_legal(logic [7:0] c);
    return c == ZERO || $onehot(c);
  endfunction

  function automatic int centre(logic [7:0] c);
    if (c == ZERO) return 0;
    for (int b = 0; b < 8; b++)
      if (c[b]) return b >= 4 ? -28672 + 8192 * (7 - b) : 4096 + 8192 * (3 - b);
    return 0;
  endfunction

  function automatic int slew(int a, int t);
    if (t > a) return (t - a > STEP_SZ) ? a + STEP_SZ : t;
    return (a - t > STEP_SZ) ? a - STEP_SZ : t;
  endfunction

  // a code is taken when its run of identical samples first reaches STABLE; reset counts as a run of 2
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_val <= ZERO; m_run <= 2; m_target <= 0; m_err <= 1'b0;
    end else begin
      if (m_run == STABLE) begin
        if (is_legal(m_val)) begin m_target <= centre(m_val); m_err <= 1'b0; end
        else m_err <= 1'b1;
      end
      if (code == m_val) m_run <= (m_run < 1000) ? m_run + 1 : m_run;
      else begin m_val <= code; m_run <= 1; end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic hold(input logic [7:0] c, input int n);
    code = c;
    repeat (n) cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; out_ready = 1'b1; code = ZERO;
    cyc(); cyc();
    rst = 1'b0; m_accel = 0;
  endtask

  task automatic tx(output logic signed [15:0] a, output logic v);
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    a = accel; v = out_valid;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b1; #2;
    checks += 4;
    if (accel !== 16'sd0) begin failures++; $display("FAIL reset_accel got=%0d want=0", accel); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    if (code_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", code_err); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    cyc(); cyc(); rst = 1'b0; m_accel = 0;
  endtask

  task automatic test_ramp();
    logic signed [15:0] a; logic v; int want;
    hold(8'b0000_0001, 5);
    for (int k = 1; k <= 30; k++) begin
      want = (k * STEP_SZ > 28672) ? 28672 : k * STEP_SZ;
      m_accel = slew(m_accel, m_target);
      tx(a, v);
      checks++;
      if (a !== 16'(want) || v !== 1'b1) begin
        failures++; $display("FAIL ramp_%0d got=%0d/%b want=%0d/1", k, a, v, want);
      end
    end
  endtask

  task automatic test_illegal();
    logic signed [15:0] a; logic v;
    hold(8'b0000_0011, 5);
    checks++;
    if (code_err !== 1'b1) begin failures++; $display("FAIL illegal_err got=%b want=1", code_err); end
    m_accel = slew(m_accel, m_target);
    tx(a, v);
    checks++;
    if (a !== 16'sd28672) begin failures++; $display("FAIL illegal_hold got=%0d want=28672", a); end
    hold(8'b0000_1000, 5);
    checks++;
    if (code_err !== 1'b0) begin failures++; $display("FAIL legal_err_clear got=%b want=0", code_err); end
    for (int k = 0; k < 24; k++) begin
      m_accel = slew(m_accel, m_target);
      tx(a, v);
      checks++;
      if (a !== 16'(m_accel)) begin failures++; $display("FAIL down_%0d got=%0d want=%0d", k, a, m_accel); end
    end
    checks++;
    if (a !== 16'sd4096) begin failures++; $display("FAIL down_final got=%0d want=4096", a); end
  endtask

  task automatic test_glitch();
    logic signed [15:0] a; logic v;
    hold(8'b0000_0001, 5);
    hold(8'b1000_0000, 2);
    hold(8'b0000_0001, 6);
    checks++;
    if (code_err !== 1'b0) begin failures++; $display("FAIL glitch_err got=%b want=0", code_err); end
    m_accel = slew(m_accel, m_target);
    tx(a, v);
    checks++;
    if (a !== 16'sd5120) begin failures++; $display("FAIL glitch_step got=%0d want=5120", a); end
  endtask

  task automatic test_step_overrun();
    do_reset();
    tick = 1'b1; cyc(); cyc(); tick = 1'b0;
    checks += 2;
    if (overrun !== 1'b1) begin failures++; $display("FAIL step_tick_overrun got=%b want=1", overrun); end
    if (out_valid !== 1'b1) begin failures++; $display("FAIL step_tick_valid got=%b want=1", out_valid); end
    cyc();
    checks += 2;
    if (overrun !== 1'b1) begin failures++; $display("FAIL step_tick_sticky got=%b want=1", overrun); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL step_tick_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_overrun();
    do_reset();
    hold(8'b0000_0001, 5);
    out_ready = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b want=0", out_valid); end
    cyc();
    checks += 2;
    if (accel !== 16'sd1024 || out_valid !== 1'b1) begin
      failures++; $display("FAIL ovr_first got=%0d/%b want=1024/1", accel, out_valid);
    end
    if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_early got=%b want=0", overrun); end
    tick = 1'b1; cyc(); tick = 1'b0;
    repeat (3) cyc();
    checks += 2;
    if (accel !== 16'sd1024 || out_valid !== 1'b1) begin
      failures++; $display("FAIL ovr_held got=%0d/%b want=1024/1", accel, out_valid);
    end
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set got=%b want=1", overrun); end
    out_ready = 1'b1; cyc();
    repeat (3) cyc();
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL ovr_drain got=%b want=0", out_valid); end
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    hold(8'b0000_0001, 5);
    out_ready = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    tick = 1'b1; out_ready = 1'b1; cyc(); tick = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b want=0", out_valid); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%b want=0", overrun); end
    cyc();
    checks += 2;
    if (accel !== 16'sd2048 || out_valid !== 1'b1) begin
      failures++; $display("FAIL b2b_next got=%0d/%b want=2048/1", accel, out_valid);
    end
    if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun2 got=%b want=0", overrun); end
    cyc(); m_accel = 2048;
  endtask

  task automatic test_reset_mid();
    logic signed [15:0] a; logic v;
    hold(8'b0000_0011, 5);
    out_ready = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    rst = 1'b1; #1;
    checks += 4;
    if (accel !== 16'sd0) begin failures++; $display("FAIL mid_rst_accel got=%0d want=0", accel); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
    if (code_err !== 1'b0) begin failures++; $display("FAIL mid_rst_err got=%b want=0", code_err); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL mid_rst_overrun got=%b want=0", overrun); end
    cyc(); cyc();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_glitch got=%b want=0", out_valid); end
    rst = 1'b0; out_ready = 1'b1; m_accel = 0;
    hold(8'b0000_0001, 5);
    m_accel = slew(m_accel, m_target);
    tx(a, v);
    checks++;
    if (a !== 16'sd1024 || v !== 1'b1) begin failures++; $display("FAIL resume got=%0d/%b want=1024/1", a, v); end
  endtask

  task automatic test_random();
    logic signed [15:0] a; logic v; logic [7:0] c; int r, len;
    do_reset();
    for (int s = 0; s < 40; s++) begin
      r = $urandom_range(0, 11);
      c = (r == 8) ? ZERO : (r < 8) ? 8'(1 << r) : 8'($urandom_range(0, 255));
      len = $urandom_range(1, 8);
      hold(c, len);
      if (len >= 6) begin
        m_accel = slew(m_accel, m_target);
        tx(a, v);
        checks++;
        if (a !== 16'(m_accel) || v !== 1'b1 || code_err !== m_err) begin
          failures++;
          $display("FAIL rand_%0d code=%b got=%0d/%b/%b want=%0d/1/%b", s, c, a, v, code_err, m_accel, m_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_illegal();
    test_glitch();
    test_step_overrun();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
